// File: rtl/xmod_add_responder_if.sv
// Request/response bundle for the A+B responder: operand request channel and tagged response
// channel, each with a valid/ready handshake.
interface xmod_add_responder_if #(
  parameter int unsigned NA    = 8,
  parameter int unsigned NOUT  = 4,
  parameter int unsigned NTAG  = 4,
  parameter int unsigned DEPTH = 2
);
  logic                       req_valid;
  logic                       req_ready;
  logic [NA-1:0]              a;
  logic [NA-1:0]              b;
  logic [NTAG-1:0]            req_tag;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [NOUT-1:0]            xout;
  logic                       ovf;
  logic [NTAG-1:0]            rsp_tag;
  logic [$clog2(DEPTH):0]     count;

  modport master (
    output req_valid, a, b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, xout, ovf, rsp_tag, count
  );

  modport slave (
    input  req_valid, a, b, req_tag, rsp_ready,
    output req_ready, rsp_valid, xout, ovf, rsp_tag, count
  );
endinterface

// File: rtl/xmod_add_responder.sv
// Handshaked A+B responder: each accepted request yields a truncated sum, overflow flag and echoed
// tag, queued in an in-order circular FIFO so the caller can stall the response side.
module xmod_add_responder #(
  parameter int unsigned NA    = 8,
  parameter int unsigned NOUT  = 4,
  parameter int unsigned NTAG  = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  xmod_add_responder_if.slave  bus_io
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef struct packed {
    logic [NOUT-1:0] xout;
    logic            ovf;
    logic [NTAG-1:0] tag;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            push;
  logic            pop;
  logic [NA:0]     sum;
  logic [NOUT-1:0] wr_xout;
  logic            wr_ovf;
  entry_t          wr_entry;
  entry_t          head;

  assign sum = {1'b0, bus_io.a} + {1'b0, bus_io.b};

  // A result field at least as wide as the full sum can never overflow.
  generate
    if (NOUT > NA) begin : g_wide_result
      assign wr_xout = NOUT'(sum);
      assign wr_ovf  = 1'b0;
    end else begin : g_trunc_result
      assign wr_xout = sum[NOUT-1:0];
      assign wr_ovf  = |sum[NA:NOUT];
    end
  endgenerate

  always_comb begin
    wr_entry      = '0;
    wr_entry.xout = wr_xout;
    wr_entry.ovf  = wr_ovf;
    wr_entry.tag  = bus_io.req_tag;
  end

  // Ready while full is allowed when the head leaves in the same cycle.
  assign bus_io.req_ready = (count_q < DepthCnt) | bus_io.rsp_ready;
  assign bus_io.rsp_valid = (count_q != '0);

  assign push = bus_io.req_valid & bus_io.req_ready;
  assign pop  = bus_io.rsp_valid & bus_io.rsp_ready;

  assign head           = mem_q[rptr_q];
  assign bus_io.xout    = head.xout;
  assign bus_io.ovf     = head.ovf;
  assign bus_io.rsp_tag = head.tag;
  assign bus_io.count   = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head fields read zero until the first push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push) begin
        mem_q[wptr_q] <= wr_entry;
      end
    end
  end

endmodule
